read_arbiter_rr_tracked: RTL and testbench

Round-robin arbiter that shares the single read port of a dual-port BRAM among NUM_LOADS load requesters in a storeless or mixed memory controller.
- Accepts load addresses, issues one BRAM read per cycle, and steers the returned word into a per-requester output register held until the consumer accepts it.
- Counts outstanding loads and exports an idle flag. The memory controller's control unit uses that flag as its "all requests done" condition, so loads are covered as well as stores.

---
 rtl/read_arbiter_rr_tracked_if.sv | 39 +++
 rtl/read_arbiter_rr_tracked.sv | 117 +++++++++++
 tb/tb_read_arbiter_rr_tracked.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/read_arbiter_rr_tracked_if.sv
// rtl/read_arbiter_rr_tracked_if.sv - load-port / BRAM-read bundle for the round-robin read arbiter
//
// Purpose: groups the requester address/data handshakes, the BRAM read port and
//          the outstanding-load tracking outputs.
// Signals:
//   ldAddr, ldAddr_valid, ldAddr_ready    per-requester address handshake (flat, i*ADDR_TYPE slices)
//   ldData, ldData_valid, ldData_ready    per-requester data handshake (flat, i*DATA_TYPE slices)
//   loadEn, loadAddr, loadData            BRAM read port (data valid one cycle after loadEn)
//   pendingCount, idle                    outstanding-load count and all-done flag
// Modports: master = requesters + BRAM side, slave = arbiter side.
interface read_arbiter_rr_tracked_if #(
    parameter int NUM_LOADS = 2,
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32
);
    localparam int CNT_W = $clog2(NUM_LOADS + 1);

    logic [NUM_LOADS*ADDR_TYPE-1:0] ldAddr;
    logic [NUM_LOADS-1:0]           ldAddr_valid;
    logic [NUM_LOADS-1:0]           ldAddr_ready;
    logic [NUM_LOADS*DATA_TYPE-1:0] ldData;
    logic [NUM_LOADS-1:0]           ldData_valid;
    logic [NUM_LOADS-1:0]           ldData_ready;
    logic                           loadEn;
    logic [ADDR_TYPE-1:0]           loadAddr;
    logic [DATA_TYPE-1:0]           loadData;
    logic [CNT_W-1:0]               pendingCount;
    logic                           idle;

    modport master (
        output ldAddr, ldAddr_valid, ldData_ready, loadData,
        input  ldAddr_ready, ldData, ldData_valid, loadEn, loadAddr, pendingCount, idle
    );

    modport slave (
        input  ldAddr, ldAddr_valid, ldData_ready, loadData,
        output ldAddr_ready, ldData, ldData_valid, loadEn, loadAddr, pendingCount, idle
    );
endinterface

// File: rtl/read_arbiter_rr_tracked.sv
// rtl/read_arbiter_rr_tracked.sv - round-robin BRAM read-port arbiter with outstanding-load tracking
//
// Purpose: shares one BRAM read port among NUM_LOADS load requesters, one read per
//          cycle, steering each returned word into a per-requester output register
//          held until accepted, and counting loads accepted but not yet delivered.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   read_arbiter_rr_tracked_if.slave (address/data handshakes, BRAM port, count/idle)
module read_arbiter_rr_tracked #(
    parameter int NUM_LOADS = 2,
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    read_arbiter_rr_tracked_if.slave  bus
);
    localparam int PTR_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
    localparam int CNT_W = $clog2(NUM_LOADS + 1);

    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_LOADS-1:0] r_inflight;
    logic [NUM_LOADS-1:0] r_data_valid;
    logic [DATA_TYPE-1:0] r_data_reg [NUM_LOADS];
    logic [CNT_W-1:0]     r_pending;

    logic [NUM_LOADS-1:0] w_elig;
    logic [NUM_LOADS-1:0] w_grant;
    logic [NUM_LOADS-1:0] w_handshake;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [ADDR_TYPE-1:0] w_addr;
    logic [CNT_W-1:0]     w_pops;

    assign w_handshake = r_data_valid & bus.ldData_ready;

    // A requester may issue only if no read is already in flight for it and its
    // output register is empty or being emptied this cycle, so a capture can never
    // overwrite an unaccepted word.
    assign w_elig = bus.ldAddr_valid & ~r_inflight & (~r_data_valid | bus.ldData_ready);

    // Rotating priority: distance k=1 from the last winner is searched first.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= NUM_LOADS; k++) begin
            for (int i = 0; i < NUM_LOADS; i++) begin
                if (!w_found && w_elig[i] && (((int'(r_ptr) + k) % NUM_LOADS) == i)) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_win      = PTR_W'(i);
                end
            end
        end
        if (rst) begin
            w_grant = '0;
            w_found = 1'b0;
            w_win   = r_ptr;
        end
    end

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            if (w_grant[i]) begin
                w_addr = bus.ldAddr[i*ADDR_TYPE +: ADDR_TYPE];
            end
        end
    end

    always_comb begin
        w_pops = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            w_pops = w_pops + CNT_W'(w_handshake[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= PTR_W'(NUM_LOADS - 1);
            r_inflight   <= '0;
            r_data_valid <= '0;
            r_pending    <= '0;
            for (int i = 0; i < NUM_LOADS; i++) begin
                r_data_reg[i] <= '0;
            end
        end else begin
            if (w_found) begin
                r_ptr <= w_win;
            end
            // A read is in flight for exactly the cycle after its grant.
            r_inflight <= w_grant;
            for (int i = 0; i < NUM_LOADS; i++) begin
                if (r_inflight[i]) begin
                    r_data_reg[i]   <= bus.loadData;
                    r_data_valid[i] <= 1'b1;
                end else if (w_handshake[i]) begin
                    r_data_valid[i] <= 1'b0;
                end
            end
            r_pending <= r_pending + CNT_W'(w_found) - w_pops;
        end
    end

    assign bus.ldAddr_ready = w_grant;
    assign bus.loadEn       = w_found;
    assign bus.loadAddr     = w_addr;
    assign bus.ldData_valid = r_data_valid;
    assign bus.pendingCount = r_pending;
    assign bus.idle         = (r_pending == '0);

    for (genvar g = 0; g < NUM_LOADS; g++) begin : g_ld_data
        assign bus.ldData[g*DATA_TYPE +: DATA_TYPE] = r_data_reg[g];
    end
endmodule

// File: tb/tb_read_arbiter_rr_tracked.sv
// tb/tb_read_arbiter_rr_tracked.sv - self-checking bench for read_arbiter_rr_tracked
module tb_read_arbiter_rr_tracked;
    localparam int N = 2;
    localparam int D = 32;
    localparam int A = 32;

    typedef struct {
        logic [A-1:0] addr;
        int           cyc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_arbiter_rr_tracked_if #(.NUM_LOADS(N), .DATA_TYPE(D), .ADDR_TYPE(A)) bus ();

    read_arbiter_rr_tracked #(.NUM_LOADS(N), .DATA_TYPE(D), .ADDR_TYPE(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ptr   = N - 1;
    ent_t q [N][$];

    function automatic logic [D-1:0] mem(logic [A-1:0] a);
        if (a == 32'h10) return 32'hAAAA;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: each requester owns a queue of accepted loads; an entry becomes
    // visible two cycles after its grant and leaves when the consumer takes it.
    task automatic tick();
        bit           deliv [N];
        bit           elig  [N];
        bit           found;
        int           win;
        int           j;
        int           cnt;
        logic [A-1:0] waddr;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_valid;
        #1;
        found = 0;
        win   = 0;
        waddr = '0;
        cnt   = 0;
        for (int i = 0; i < N; i++) begin
            deliv[i]     = (q[i].size() > 0) && (cyc >= q[i][0].cyc + 2);
            elig[i]      = bus.ldAddr_valid[i] && (q[i].size() == 0 || (deliv[i] && bus.ldData_ready[i]));
            exp_valid[i] = deliv[i];
            cnt          = cnt + q[i].size();
        end
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                j = (ptr + k) % N;
                if (!found && elig[j]) begin
                    found = 1;
                    win   = j;
                end
            end
        end
        exp_grant = found ? (N'(1) << win) : '0;
        if (found) waddr = bus.ldAddr[win*A +: A];
        check("ldAddr_ready", 64'(bus.ldAddr_ready), 64'(exp_grant));
        check("loadEn", 64'(bus.loadEn), 64'(found));
        check("loadAddr", 64'(bus.loadAddr), 64'(waddr));
        check("ldData_valid", 64'(bus.ldData_valid), 64'(exp_valid));
        check("pendingCount", 64'(bus.pendingCount), 64'(cnt));
        check("idle", 64'(bus.idle), 64'(cnt == 0));
        for (int i = 0; i < N; i++) begin
            if (deliv[i]) check($sformatf("ldData%0d", i), 64'(bus.ldData[i*D +: D]), 64'(mem(q[i][0].addr)));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            ptr = N - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (deliv[i] && bus.ldData_ready[i]) void'(q[i].pop_front());
            end
            if (found) begin
                q[win].push_back('{addr: waddr, cyc: cyc});
                ptr = win;
            end
        end
        cyc++;
        #1;
        // BRAM answers the modelled read; otherwise the bus carries junk.
        bus.loadData = found ? mem(waddr) : D'($urandom());
    endtask

    task automatic set_in(logic [N-1:0] av, logic [N-1:0] dr, logic [A-1:0] a0, logic [A-1:0] a1);
        bus.ldAddr_valid = av;
        bus.ldData_ready = dr;
        bus.ldAddr       = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        set_in(2'b00, 2'b00, '0, '0);
        bus.loadData = '0;
        @(posedge clk);
        #1;
        tick();
        check("reset_ldData", 64'(bus.ldData), 64'h0);
        check("reset_idle", 64'(bus.idle), 64'h1);

        // Idle after reset release.
        rst = 1'b0;
        repeat (5) tick();

        // Single load to requester 0.
        set_in(2'b01, 2'b11, 32'h10, 32'h0);
        #1;
        check("single_loadAddr", 64'(bus.loadAddr), 64'h10);
        tick();
        set_in(2'b00, 2'b11, 32'h0, 32'h0);
        tick();
        #1;
        check("single_data", 64'(bus.ldData[D-1:0]), 64'hAAAA);
        check("single_valid", 64'(bus.ldData_valid), 64'h1);
        repeat (3) tick();

        // Both requesters continuously valid, always ready.
        for (int s = 0; s < 10; s++) begin
            set_in(2'b11, 2'b11, A'($urandom()), A'($urandom()));
            tick();
        end

        // Backpressure on port 0 for 6 cycles, then release.
        for (int s = 0; s < 6; s++) begin
            set_in(2'b11, 2'b10, A'($urandom()), A'($urandom()));
            tick();
        end
        for (int s = 0; s < 6; s++) begin
            set_in(2'b11, 2'b11, A'($urandom()), A'($urandom()));
            tick();
        end

        // Reset mid-stream with reads in flight and data held.
        for (int s = 0; s < 3; s++) begin
            set_in(2'b11, 2'b00, A'($urandom()), A'($urandom()));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(2'b00, 2'b00, '0, '0);
        tick();
        check("post_reset_valid", 64'(bus.ldData_valid), 64'h0);
        check("post_reset_idle", 64'(bus.idle), 64'h1);
        set_in(2'b11, 2'b11, 32'h100, 32'h200);
        #1;
        check("post_reset_first_grant", 64'(bus.ldAddr_ready), 64'h1);
        tick();

        // Randomized traffic with occasional reset.
        for (int s = 0; s < 400; s++) begin
            set_in(N'($urandom()), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)},
                   A'($urandom()), A'($urandom()));
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
